// File: rtl/exec_seq_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the exec_sequencer block: opcode map, FSM states
// and instruction-word field positions.
package exec_seq_pkg;

    localparam int OP_LOAD    = 12;
    localparam int OP_STORE   = 13;
    localparam int OP_NOP     = 14;
    localparam int OP_HALT    = 15;
    localparam int ALU_OP_MAX = 11;

    // Least-significant bit of each field in the 32-bit instruction word
    localparam int OPC_LSB = 28;
    localparam int A1_LSB  = 23;
    localparam int A2_LSB  = 18;
    localparam int A3_LSB  = 13;

    localparam int WAIT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_READ,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

endpackage

// File: rtl/exec_sequencer_if.sv
`timescale 1ns/1ps
// Instruction handshake and memory request channel of the exec_sequencer.
// slave = sequencer side, master = instruction source / memory side.
interface exec_sequencer_if;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;

    modport slave (
        input  instr_valid,
        input  instr,
        input  mem_ack,
        output instr_ready,
        output mem_req,
        output mem_we
    );

    modport master (
        output instr_valid,
        output instr,
        output mem_ack,
        input  instr_ready,
        input  mem_req,
        input  mem_we
    );

endinterface

// File: rtl/exec_sequencer_decode.sv
`timescale 1ns/1ps
// seq_decode: combinational opcode classifier for the exec_sequencer.
module seq_decode
    import exec_seq_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] opcode,
    output logic           is_alu,
    output logic           is_load,
    output logic           is_store,
    output logic           is_nop,
    output logic           is_halt
);

    always_comb begin
        is_alu   = (opcode <= OPW'(ALU_OP_MAX));
        is_load  = (opcode == OPW'(OP_LOAD));
        is_store = (opcode == OPW'(OP_STORE));
        is_nop   = (opcode == OPW'(OP_NOP));
        is_halt  = (opcode == OPW'(OP_HALT));
    end

endmodule

// File: rtl/exec_sequencer.sv
`timescale 1ns/1ps
// exec_sequencer: multi-cycle control FSM sequencing one instruction through
// register file, ALU and memory. Define EXEC_SEQ_PERF_EN for retired/stall counters.
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int OPW         = 4,
    parameter int AW          = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    exec_sequencer_if.slave bus,
    output logic [AW-1:0]  rf_addr1,
    output logic [AW-1:0]  rf_addr2,
    output logic [AW-1:0]  rf_addr3,
    output logic           rf_read,
    output logic           rf_write,
    output logic           wb_sel,
    output logic [OPW-1:0] alu_opcode,
    output logic           alu_en,
    input  logic [3:0]     alu_flag,
    output logic [3:0]     flag_reg,
    output logic           halted,
    output logic           mem_err
`ifdef EXEC_SEQ_PERF_EN
    ,
    output logic [15:0]    retired_cnt,
    output logic [15:0]    stall_cnt
`endif
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                is_alu, is_load, is_store, is_nop, is_halt;
    logic                unused_instr_bits;

    assign unused_instr_bits = ^bus.instr[A3_LSB-1:0];

    // Classification works on the latched opcode, which doubles as alu_opcode
    seq_decode #(.OPW(OPW)) u_decode (
        .opcode   (alu_opcode),
        .is_alu   (is_alu),
        .is_load  (is_load),
        .is_store (is_store),
        .is_nop   (is_nop),
        .is_halt  (is_halt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            wait_cnt        <= '0;
            bus.instr_ready <= 1'b1;
            bus.mem_req     <= 1'b0;
            bus.mem_we      <= 1'b0;
            rf_addr1        <= '0;
            rf_addr2        <= '0;
            rf_addr3        <= '0;
            rf_read         <= 1'b0;
            rf_write        <= 1'b0;
            wb_sel          <= 1'b0;
            alu_opcode      <= '0;
            alu_en          <= 1'b0;
            flag_reg        <= '0;
            halted          <= 1'b0;
            mem_err         <= 1'b0;
        end else begin
            // Strobes are one-cycle unless a state explicitly re-asserts them
            bus.instr_ready <= 1'b0;
            bus.mem_req     <= 1'b0;
            rf_read         <= 1'b0;
            rf_write        <= 1'b0;
            alu_en          <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        alu_opcode <= bus.instr[OPC_LSB +: OPW];
                        rf_addr1   <= bus.instr[A1_LSB +: AW];
                        rf_addr2   <= bus.instr[A2_LSB +: AW];
                        rf_addr3   <= bus.instr[A3_LSB +: AW];
                        state      <= ST_DECODE;
                    end else begin
                        bus.instr_ready <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (is_nop) begin
                        state           <= ST_IDLE;
                        bus.instr_ready <= 1'b1;
                    end else if (is_halt) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else begin
                        state   <= ST_READ;
                        rf_read <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (is_alu) begin
                        state  <= ST_EXEC;
                        alu_en <= 1'b1;
                    end else begin
                        state       <= ST_MEM;
                        bus.mem_req <= 1'b1;
                        bus.mem_we  <= is_store;
                        wait_cnt    <= '0;
                    end
                end
                ST_EXEC: begin
                    flag_reg <= alu_flag;
                    wb_sel   <= 1'b0;
                    rf_write <= (rf_addr1 != '0);
                    state    <= ST_WB;
                end
                ST_MEM: begin
                    // An ack in the final allowed cycle still wins over the timeout
                    if (bus.mem_ack) begin
                        if (is_load) begin
                            state    <= ST_WB;
                            wb_sel   <= 1'b1;
                            rf_write <= (rf_addr1 != '0);
                        end else begin
                            state           <= ST_IDLE;
                            bus.instr_ready <= 1'b1;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state           <= ST_IDLE;
                        mem_err         <= 1'b1;
                        bus.instr_ready <= 1'b1;
                    end else begin
                        bus.mem_req <= 1'b1;
                        wait_cnt    <= wait_cnt + 1'b1;
                    end
                end
                ST_WB: begin
                    state           <= ST_IDLE;
                    bus.instr_ready <= 1'b1;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state           <= ST_IDLE;
                    bus.instr_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef EXEC_SEQ_PERF_EN
    logic retire, stall;

    assign retire = (state == ST_WB)
                  || (state == ST_MEM && bus.mem_ack && is_store)
                  || (state == ST_DECODE && is_nop);
    assign stall  = (state == ST_MEM) && !bus.mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (retire) retired_cnt <= retired_cnt + 16'd1;
            if (stall)  stall_cnt   <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
`timescale 1ns/1ps
// Directed bench for exec_sequencer: ALU, LOAD, STORE (ack at limit and
// timeout), R0 write suppression, NOP, HALT and asynchronous reset.
module tb_exec_sequencer;

    logic       clk;
    logic       rst_n;
    logic [4:0] rf_addr1, rf_addr2, rf_addr3;
    logic       rf_read, rf_write, wb_sel, alu_en, halted, mem_err;
    logic [3:0] alu_opcode, alu_flag, flag_reg;
`ifdef EXEC_SEQ_PERF_EN
    logic [15:0] retired_cnt, stall_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    exec_sequencer_if bus();

    exec_sequencer #(.MEM_TIMEOUT(15), .OPW(4), .AW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .rf_addr1   (rf_addr1),
        .rf_addr2   (rf_addr2),
        .rf_addr3   (rf_addr3),
        .rf_read    (rf_read),
        .rf_write   (rf_write),
        .wb_sel     (wb_sel),
        .alu_opcode (alu_opcode),
        .alu_en     (alu_en),
        .alu_flag   (alu_flag),
        .flag_reg   (flag_reg),
        .halted     (halted),
        .mem_err    (mem_err)
`ifdef EXEC_SEQ_PERF_EN
        ,
        .retired_cnt(retired_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; drive and sample away from it
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] mk(input int op, input int a1, input int a2, input int a3);
        mk = {op[3:0], a1[4:0], a2[4:0], a3[4:0], 13'h1ABC};
    endfunction

    // Present an instruction while IDLE; returns in cycle 1 (DECODE)
    task automatic issue(input logic [31:0] word, input logic hold_valid);
        bus.instr_valid = 1'b1;
        bus.instr       = word;
        next_cycle();
        bus.instr_valid = hold_valid;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.mem_ack     = 1'b0;
        alu_flag        = 4'b1010;
        #12;
        check("rst_instr_ready", 32'(bus.instr_ready), 32'd1);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        rst_n = 1'b1;
        next_cycle();
        check("idle_ready", 32'(bus.instr_ready), 32'd1);

        // ALU op 3: rf_read c2, alu_en c3, rf_write c4, ready c5
        issue(mk(3, 5, 1, 2), 1'b0);
        check("alu_c1_ready", 32'(bus.instr_ready), 32'd0);
        check("alu_c1_rd", 32'(rf_read), 32'd0);
        next_cycle();
        check("alu_c2_rd", 32'(rf_read), 32'd1);
        check("alu_c2_a2", 32'(rf_addr2), 32'd1);
        check("alu_c2_a3", 32'(rf_addr3), 32'd2);
        next_cycle();
        check("alu_c3_en", 32'(alu_en), 32'd1);
        check("alu_c3_op", 32'(alu_opcode), 32'd3);
        check("alu_c3_flag", 32'(flag_reg), 32'd0);
        next_cycle();
        alu_flag = 4'b0000;
        check("alu_c4_wr", 32'(rf_write), 32'd1);
        check("alu_c4_a1", 32'(rf_addr1), 32'd5);
        check("alu_c4_wbsel", 32'(wb_sel), 32'd0);
        check("alu_c4_flag", 32'(flag_reg), 32'hA);
        check("alu_c4_en", 32'(alu_en), 32'd0);
        next_cycle();
        check("alu_c5_ready", 32'(bus.instr_ready), 32'd1);
        check("alu_c5_wr", 32'(rf_write), 32'd0);

        // LOAD addr1=7, ack after 3 wait cycles
        issue(mk(12, 7, 3, 4), 1'b0);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            check("ld_mem_req", 32'(bus.mem_req), 32'd1);
            check("ld_mem_we", 32'(bus.mem_we), 32'd0);
            check("ld_no_wr", 32'(rf_write), 32'd0);
            if (i == 3) bus.mem_ack = 1'b1;
        end
        next_cycle();
        bus.mem_ack = 1'b0;
        check("ld_wb_wr", 32'(rf_write), 32'd1);
        check("ld_wb_sel", 32'(wb_sel), 32'd1);
        check("ld_wb_a1", 32'(rf_addr1), 32'd7);
        check("ld_wb_req", 32'(bus.mem_req), 32'd0);
        check("ld_flag_kept", 32'(flag_reg), 32'hA);
        next_cycle();
        check("ld_ready", 32'(bus.instr_ready), 32'd1);

        // STORE acked in the 15th (last allowed) MEM cycle -> success
        issue(mk(13, 9, 1, 1), 1'b0);
        next_cycle();
        for (int i = 0; i < 15; i++) begin
            next_cycle();
            check("st_lim_req", 32'(bus.mem_req), 32'd1);
            if (i == 14) bus.mem_ack = 1'b1;
        end
        next_cycle();
        bus.mem_ack = 1'b0;
        check("st_lim_req_off", 32'(bus.mem_req), 32'd0);
        check("st_lim_no_err", 32'(mem_err), 32'd0);
        check("st_lim_no_wr", 32'(rf_write), 32'd0);
        check("st_lim_ready", 32'(bus.instr_ready), 32'd1);

        // STORE with no ack -> timeout after 15 cycles
        issue(mk(13, 4, 2, 2), 1'b0);
        next_cycle();
        for (int i = 0; i < 15; i++) begin
            next_cycle();
            check("st_to_req", 32'(bus.mem_req), 32'd1);
            check("st_to_we", 32'(bus.mem_we), 32'd1);
            check("st_to_err_early", 32'(mem_err), 32'd0);
        end
        next_cycle();
        check("st_to_req_off", 32'(bus.mem_req), 32'd0);
        check("st_to_err", 32'(mem_err), 32'd1);
        check("st_to_no_wr", 32'(rf_write), 32'd0);
        check("st_to_ready", 32'(bus.instr_ready), 32'd1);

        // Spurious ack while idle is ignored
        bus.mem_ack = 1'b1;
        next_cycle();
        bus.mem_ack = 1'b0;
        check("spur_req", 32'(bus.mem_req), 32'd0);
        check("spur_ready", 32'(bus.instr_ready), 32'd1);

        // ALU op into R0: full sequence, write suppressed
        alu_flag = 4'b0110;
        issue(mk(5, 0, 6, 7), 1'b0);
        next_cycle();
        check("r0_rd", 32'(rf_read), 32'd1);
        next_cycle();
        check("r0_en", 32'(alu_en), 32'd1);
        check("r0_op", 32'(alu_opcode), 32'd5);
        next_cycle();
        check("r0_no_wr", 32'(rf_write), 32'd0);
        check("r0_flag", 32'(flag_reg), 32'h6);
        next_cycle();
        check("r0_ready", 32'(bus.instr_ready), 32'd1);
        check("r0_err_sticky", 32'(mem_err), 32'd1);

        // NOP: ready again in cycle 2, flags untouched
        alu_flag = 4'b1111;
        issue(mk(14, 3, 3, 3), 1'b0);
        check("nop_c1_ready", 32'(bus.instr_ready), 32'd0);
        next_cycle();
        check("nop_c2_ready", 32'(bus.instr_ready), 32'd1);
        check("nop_rd", 32'(rf_read), 32'd0);
        check("nop_flag", 32'(flag_reg), 32'h6);
`ifdef EXEC_SEQ_PERF_EN
        check("perf_retired", 32'(retired_cnt), 32'd5);
        check("perf_stall", 32'(stall_cnt), 32'd32);
`endif

        // HALT with instr_valid held high
        issue(mk(15, 1, 1, 1), 1'b1);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_ready", 32'(bus.instr_ready), 32'd0);
            next_cycle();
        end
        rst_n = 1'b0;
        #1;
        check("halt_rst_halted", 32'(halted), 32'd0);
        check("halt_rst_ready", 32'(bus.instr_ready), 32'd1);
        bus.instr_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        next_cycle();
        check("halt_after_idle", 32'(bus.instr_ready), 32'd1);

        // Asynchronous reset in the middle of a LOAD's MEM phase
        issue(mk(12, 8, 1, 1), 1'b0);
        next_cycle();
        next_cycle();
        check("ldrst_req", 32'(bus.mem_req), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("ldrst_req_off", 32'(bus.mem_req), 32'd0);
        check("ldrst_ready", 32'(bus.instr_ready), 32'd1);
        check("ldrst_a1", 32'(rf_addr1), 32'd0);
        check("ldrst_flag", 32'(flag_reg), 32'd0);
        check("ldrst_err", 32'(mem_err), 32'd0);
`ifdef EXEC_SEQ_PERF_EN
        check("ldrst_retired", 32'(retired_cnt), 32'd0);
        check("ldrst_stall", 32'(stall_cnt), 32'd0);
`endif
        #2;
        rst_n = 1'b1;
        next_cycle();
        check("ldrst_idle_req", 32'(bus.mem_req), 32'd0);
        check("ldrst_idle_ready", 32'(bus.instr_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle control FSM that sequences one 32-bit instruction at a time through the processor datapath: register file, ALU, data memory and flag register.
- Accepts instructions over a valid/ready handshake and decodes opcode and register fields.
- Drives register-file read/write strobes, ALU opcode/enable and memory request strobes; latches ALU flags.
- Sits between the instruction source and the CU/EU/ALU/memory datapath; carries no data-path values itself.

Parameters:
- MEM_TIMEOUT, 15, max cycles to wait for mem_ack before aborting (1..255)
- OPW, 4, opcode width
- AW, 5, register address width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction available
- instr_ready  out  1  sequencer can accept an instruction
- instr  in  32  instruction word: [31:28] opcode, [27:23] addr1 (dest), [22:18] addr2, [17:13] addr3, rest ignored
- rf_addr1/rf_addr2/rf_addr3  out  5 each  latched register fields
- rf_read  out  1  register read strobe
- rf_write  out  1  register write strobe
- wb_sel  out  1  writeback source: 0 = ALU, 1 = memory
- alu_opcode  out  4  opcode to ALU
- alu_en  out  1  ALU operate strobe
- alu_flag  in  4  ALU flags, valid while alu_en=1
- flag_reg  out  4  latched flag register
- mem_req  out  1  memory access request
- mem_we  out  1  1 = store, 0 = load; valid with mem_req
- mem_ack  in  1  memory completion
- halted  out  1  HALT executed
- mem_err  out  1  sticky memory-timeout error

Behaviour:
- Opcode map:
  - 0-11: ALU ops
  - 12: LOAD
  - 13: STORE
  - 14: NOP
  - 15: HALT
- Reset: state IDLE; all outputs 0 except instr_ready=1. Reset mid-operation aborts immediately and drops any strobe asynchronously.
- States and transitions:
  - IDLE: instr_ready=1. On instr_valid, latch instr and go to DECODE. instr_ready=0 in every other state.
  - DECODE (1 cycle): NOP -> IDLE; HALT -> HALT; all others -> READ.
  - READ (1 cycle): rf_read=1. ALU op -> EXEC; LOAD/STORE -> MEM.
  - EXEC (1 cycle): alu_en=1, alu_opcode=op. flag_reg<=alu_flag at the end of the cycle. Then -> WB.
  - MEM: mem_req=1 and mem_we held stable until mem_ack. LOAD -> WB; STORE -> IDLE.
    - Wait counter starts at 0 on entry. If mem_ack is not seen after MEM_TIMEOUT cycles, drop mem_req, set mem_err, go to IDLE with no writeback.
    - mem_ack on the same cycle the timeout expires counts as success.
  - WB (1 cycle): rf_write=1, wb_sel=0 for ALU ops, 1 for LOAD. rf_write is suppressed when rf_addr1==0 (R0 is read-only). Then -> IDLE.
  - HALT: halted=1; remains until reset; instr_valid ignored.
- Latency, with handshake at edge 0:
  - ALU: rf_write in cycle 4; instr_ready back in cycle 5 (5-cycle throughput).
  - NOP: instr_ready back in cycle 2.
  - LOAD with ack on first MEM cycle: WB in cycle 4.
- Field and flag rules:
  - rf_addr1/2/3 and alu_opcode hold their latched values until the next accept.
  - flag_reg changes only in EXEC; LOAD, STORE and NOP leave it unchanged.
- Error flag: mem_err is cleared only by reset.
- Spurious mem_ack outside MEM is ignored.

Optional Feature:
- Macro: EXEC_SEQ_PERF_EN.
- Defined: adds outputs retired_cnt[15:0] and stall_cnt[15:0].
  - retired_cnt increments on each instruction completion (WB exit, STORE ack, NOP); not incremented for HALT or timeout.
  - stall_cnt increments on every MEM cycle without mem_ack.
  - Both counters wrap at 16'hFFFF->0 and reset to 0.
- Undefined: ports absent and no counter logic.

Decomposition:
- Package exec_seq_pkg:
  - opcode constants (OP_LOAD=12, OP_STORE=13, OP_NOP=14, OP_HALT=15, ALU_OP_MAX=11)
  - state enum
  - instruction field bit positions
- Sub-module seq_decode: combinational, opcode -> {is_alu, is_load, is_store, is_nop, is_halt}; instantiated once.

Test Plan:
- ALU op 3, addr1=5, addr2=1, addr3=2, alu_flag=4'b1010 -> rf_read cycle 2, alu_en with alu_opcode=3 cycle 3, rf_write with rf_addr1=5 and wb_sel=0 cycle 4, flag_reg=1010 from cycle 4, instr_ready cycle 5.
- LOAD addr1=7, mem_ack after 3 wait cycles -> mem_req high 4 cycles with mem_we=0, then rf_write with wb_sel=1; flag_reg unchanged.
- STORE with mem_ack never asserted, MEM_TIMEOUT=15 -> mem_req drops after 15 cycles, mem_err=1 sticky, no rf_write, next instruction accepted.
- ALU op with addr1=0 -> full sequence runs but rf_write stays 0. NOP -> instr_ready back after 2 cycles.
- HALT then instr_valid held high -> halted=1, instr_ready=0 indefinitely; rst_n pulse -> IDLE, halted=0.
- rst_n asserted during MEM of a LOAD -> mem_req drops without waiting for clk; all outputs at reset values; with EXEC_SEQ_PERF_EN, retired_cnt=0.
